wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Writeback stage directly upstream of the register file. Merges ALU and load-unit results
//  into the register file's single write port (wr_en/wr1_addr/wr1_data).
//  Each source gets a small FIFO. A fixed-priority arbiter with an anti-starvation counter
//  picks the winner. A forwarding lookup exposes in-flight values to operand fetch.
// PARAMETERS
//  DATA_W      64  result data width
//  REG_ADDR_W  6   register address width (NULL=0, G0-G30, SF=31, LR=32, SP=33)
//  NUM_REGS    34  number of architectural registers; addr >= NUM_REGS is illegal
//  FIFO_DEPTH  2   entries per source FIFO, power of 2, >= 2
//  STARVE_MAX  4   consecutive ALU losses before the ALU is forced a grant
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           asynchronous reset, active low
//  alu_valid  in   1           ALU result valid
//  alu_ready  out  1           ALU FIFO can accept
//  alu_addr   in   REG_ADDR_W  ALU destination register
//  alu_data   in   DATA_W      ALU result
//  ld_valid   in   1           load result valid
//  ld_ready   out  1           load FIFO can accept
//  ld_addr    in   REG_ADDR_W  load destination register
//  ld_data    in   DATA_W      load result
//  wr_en      out  1           register-file write enable (registered)
//  wr1_addr   out  REG_ADDR_W  register-file write address (registered)
//  wr1_data   out  DATA_W      register-file write data (registered)
//  fwd_addr   in   REG_ADDR_W  forwarding lookup address
//  fwd_hit    out  1           comb: fwd_addr matches an in-flight write
//  fwd_data   out  DATA_W      comb: data of the matching write, 0 when no hit
//  err_badaddr out 1           one-cycle pulse: a write to addr >= NUM_REGS was dropped
//  busy       out  1           any FIFO non-empty or wr_en high
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - both FIFOs emptied; in-flight results discarded, including mid-operation.
//   - wr_en=0, wr1_addr=0, wr1_data=0, err_badaddr=0, starve counter=0, busy=0.
//   - alu_ready=ld_ready=0 while in reset; both go to 1 on the first cycle after release.
//  Accept:
//   - A source's beat is accepted when valid && ready; ready = !full, computed from registered count.
//   - Addr 0 (NULL): accepted, not enqueued, no error.
//   - Addr >= NUM_REGS: accepted, not enqueued; err_badaddr=1 for the next cycle.
//  Grant (each cycle any FIFO head is valid):
//   - Exactly one head is popped and registered onto wr_en/wr1_addr/wr1_data.
//   - Default priority is load over ALU.
//   - Starve counter increments when the ALU head is valid but loses; it clears on an ALU grant
//     or when the ALU FIFO is empty.
//   - When the counter reaches STARVE_MAX, the ALU wins that cycle.
//   - No head valid -> wr_en=0; addr/data hold their previous values.
//  Latency: beat accepted at edge k into an empty FIFO, no contention -> wr_en=1 between edges
//   k+1 and k+2; the register file commits at edge k+2. Throughput: 1 write/cycle.
//  Simultaneous push and pop on a full FIFO: pop frees the slot next cycle only; ready stays 0
//   this cycle.
//  Ordering: in-order within a source. Across sources, only the grant rule applies. Issue logic
//   guarantees no two in-flight writes to the same register from different sources.
//  Forwarding (combinational):
//   - Searches the wr1 output register and all valid FIFO entries.
//   - Youngest match within the hitting source wins; FIFO entries beat the output register.
//   - fwd_addr=0 -> fwd_hit=0.
//  Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits, with no over/underflow.
// STRUCTURE
//  Shared package ember_pkg: DATA_W, REG_ADDR_W, NUM_REGS, REG_NULL=0, REG_SF=31, REG_LR=32,
//   REG_SP=33.
//  Sub-module wb_fifo: sync FIFO with {addr,data} entries and an addr-match lookup port
//   returning hit plus youngest data. Instantiated twice.
//  Arbiter, starve counter, output register and error pulse live in wb_arbiter.
// TESTING
//  1. ALU beat addr=5 data=0xAB at edge 1 -> wr_en=1, wr1_addr=5, wr1_data=0xAB during
//     cycle 2 only.
//  2. Both sources valid every cycle, distinct addrs -> load wins 4 in a row, ALU wins the
//     5th; repeats.
//  3. ALU push addr=0, then addr=40 -> never written; err_badaddr pulses once for addr=40,
//     alu_ready stays 1.
//  4. Stall drain with 2 load beats queued -> ld_ready=0; a 3rd beat is held by the source
//     and not lost.
//  5. fwd_addr=7 with ALU FIFO holding 7:0x1 then 7:0x2 -> fwd_hit=1, fwd_data=0x2;
//     fwd_addr=0 -> fwd_hit=0.
//  6. rst_n low mid-burst -> wr_en, busy and ready drop asynchronously; after release,
//     no stale write appears.

Source files
------------

// File: rtl/ember_pkg.sv
// ember_pkg: register-file geometry shared by the core, plus the writeback grant encoding.
package ember_pkg;
  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 6;
  localparam int NUM_REGS   = 34;
  localparam int REG_NULL   = 0;
  localparam int REG_SF     = 31;
  localparam int REG_LR     = 32;
  localparam int REG_SP     = 33;

  typedef enum logic [1:0] {GNT_NONE, GNT_LD, GNT_ALU} gnt_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of {addr,data} results with a youngest-match lookup port.
module wb_fifo #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Scan oldest to youngest so the last match found is the youngest.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (lk_addr != '0) &&
          (mem_addr[rd_ptr + PW'(i)] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = mem_data[rd_ptr + PW'(i)];
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load results onto the register file's single write port,
// load-first with an ALU anti-starvation override, and exposes in-flight values for forwarding.
module wb_arbiter #(
  parameter int DATA_W     = ember_pkg::DATA_W,
  parameter int REG_ADDR_W = ember_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = ember_pkg::NUM_REGS,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr1_addr,
  output logic [DATA_W-1:0]     wr1_data,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  err_badaddr,
  output logic                  busy
);
  import ember_pkg::gnt_e;
  import ember_pkg::GNT_NONE;
  import ember_pkg::GNT_LD;
  import ember_pkg::GNT_ALU;
  import ember_pkg::REG_NULL;

  localparam int SW = $clog2(STARVE_MAX + 1);

  function automatic logic addr_bad(input logic [REG_ADDR_W-1:0] a);
    return int'(a) >= NUM_REGS;
  endfunction

  logic                  rdy_en;
  logic                  alu_full, alu_empty, ld_full, ld_empty;
  logic                  alu_acc, ld_acc, alu_bad, ld_bad, alu_push, ld_push;
  logic [REG_ADDR_W-1:0] alu_head_addr, ld_head_addr;
  logic [DATA_W-1:0]     alu_head_data, ld_head_data;
  logic                  alu_lk_hit, ld_lk_hit;
  logic [DATA_W-1:0]     alu_lk_data, ld_lk_data;
  logic [SW-1:0]         starve_cnt;
  gnt_e                  gnt;

  // Ready is held low until the first edge after reset release.
  assign alu_ready = rdy_en && !alu_full;
  assign ld_ready  = rdy_en && !ld_full;
  assign alu_acc   = alu_valid && alu_ready;
  assign ld_acc    = ld_valid && ld_ready;
  assign alu_bad   = addr_bad(alu_addr);
  assign ld_bad    = addr_bad(ld_addr);
  assign alu_push  = alu_acc && !alu_bad && (alu_addr != REG_ADDR_W'(REG_NULL));
  assign ld_push   = ld_acc && !ld_bad && (ld_addr != REG_ADDR_W'(REG_NULL));

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(alu_push), .push_addr(alu_addr), .push_data(alu_data),
    .pop(gnt == GNT_ALU), .full(alu_full), .empty(alu_empty),
    .head_addr(alu_head_addr), .head_data(alu_head_data),
    .lk_addr(fwd_addr), .lk_hit(alu_lk_hit), .lk_data(alu_lk_data)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W), .DEPTH(FIFO_DEPTH)) u_ld_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(ld_push), .push_addr(ld_addr), .push_data(ld_data),
    .pop(gnt == GNT_LD), .full(ld_full), .empty(ld_empty),
    .head_addr(ld_head_addr), .head_data(ld_head_data),
    .lk_addr(fwd_addr), .lk_hit(ld_lk_hit), .lk_data(ld_lk_data)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (!alu_empty && (ld_empty || (starve_cnt == SW'(STARVE_MAX)))) gnt = GNT_ALU;
    else if (!ld_empty) gnt = GNT_LD;
  end

  // Output register stage: the popped head is presented to the register file next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en      <= 1'b0;
      wr_en       <= 1'b0;
      wr1_addr    <= '0;
      wr1_data    <= '0;
      err_badaddr <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      rdy_en      <= 1'b1;
      wr_en       <= (gnt != GNT_NONE);
      err_badaddr <= (alu_acc && alu_bad) || (ld_acc && ld_bad);
      if (gnt == GNT_ALU) begin
        wr1_addr <= alu_head_addr;
        wr1_data <= alu_head_data;
      end else if (gnt == GNT_LD) begin
        wr1_addr <= ld_head_addr;
        wr1_data <= ld_head_data;
      end
      if (alu_empty || (gnt == GNT_ALU)) starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Queued entries are younger than the output register, so they take precedence.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (ld_lk_hit) begin
      fwd_hit  = 1'b1;
      fwd_data = ld_lk_data;
    end else if (alu_lk_hit) begin
      fwd_hit  = 1'b1;
      fwd_data = alu_lk_data;
    end else if (wr_en && (fwd_addr != '0) && (wr1_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr1_data;
    end
  end

  assign busy = !alu_empty || !ld_empty || wr_en;
endmodule
